// File: rtl/sdram_work_fsm_pkg.sv
// rtl/sdram_work_fsm_pkg.sv - shared work-state codes, default timings and burst-length clamp
package sdram_work_fsm_pkg;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_state_e;

  localparam int DEF_TRCD       = 2;
  localparam int DEF_CL         = 3;
  localparam int DEF_TWR        = 2;
  localparam int DEF_TRP        = 2;
  localparam int DEF_TRFC       = 7;
  localparam int DEF_REF_PERIOD = 781;

  localparam logic [9:0] BL_MAX  = 10'd512;
  localparam logic [9:0] CNT_MAX = 10'd1023;

  function automatic logic [9:0] clamp_bl(input logic [9:0] i_len);
    logic [9:0] w_len;
    w_len = i_len;
    if (i_len == 10'd0) w_len = 10'd1;
    else if (i_len > BL_MAX) w_len = BL_MAX;
    return w_len;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - free-running refresh interval counter with a sticky refresh-pending flag
module sdram_ref_timer
  import sdram_work_fsm_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_ref_pend
);

  localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(REF_PERIOD - 1));

  // A wrap landing on the AR-entry cycle is absorbed: the flag was already set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
      r_pend <= ~i_clr & (r_pend | w_wrap);
    end
  end

  assign o_ref_pend = r_pend;

endmodule

// File: rtl/sdram_work_fsm.sv
// rtl/sdram_work_fsm.sv - SDRAM work-state sequencer: write/read/refresh arbitration and per-command timing walk
module sdram_work_fsm
  import sdram_work_fsm_pkg::*;
#(
  parameter int TRCD       = DEF_TRCD,
  parameter int CL         = DEF_CL,
  parameter int TWR        = DEF_TWR,
  parameter int TRP        = DEF_TRP,
  parameter int TRFC       = DEF_TRFC,
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sdram_init_done,
  input  logic       i_wr_req,
  input  logic       i_rd_req,
  input  logic [9:0] i_wr_burst_len,
  input  logic [9:0] i_rd_burst_len,
  output logic [3:0] o_work_state,
  output logic [9:0] o_cnt_clk,
  output logic       o_sdram_rd_wr,
  output logic       o_wr_ack,
  output logic       o_rd_valid,
  output logic       o_wr_done,
  output logic       o_rd_done,
  output logic       o_busy
);

  work_state_e r_state;
  logic [9:0]  r_cnt;
  logic [9:0]  r_bl;
  logic        r_is_wr;
  logic        r_rd_next;
  logic        r_rd_wr;
  logic        r_wr_ack;
  logic        r_rd_valid;
  logic        r_wr_done;
  logic        r_rd_done;
  logic        r_busy;

  work_state_e w_nxt_state;
  logic [9:0]  w_nxt_cnt;
  logic [9:0]  w_nxt_bl;
  logic        w_nxt_is_wr;
  logic        w_accept;
  logic        w_pick_wr;
  logic        w_last;
  logic        w_done;
  logic        w_ref_clr;
  logic        w_ref_pend;

  function automatic logic [10:0] f_dur(input work_state_e s, input logic [9:0] bl);
    logic [10:0] d;
    case (s)
      W_ACTIVE, W_READ, W_WRITE, W_PRE, W_AR: d = 11'd1;
      W_TRCD:  d = 11'(TRCD - 1);
      W_CL:    d = 11'(CL - 1);
      W_RD:    d = {1'b0, bl};
      W_WD:    d = {1'b0, bl} - 11'd1;
      W_TWR:   d = 11'(TWR);
      W_TRP:   d = 11'(TRP - 1);
      W_TRFC:  d = 11'(TRFC - 1);
      default: d = 11'd0;
    endcase
    return d;
  endfunction

  function automatic work_state_e f_succ(input work_state_e s, input logic is_wr);
    work_state_e n;
    case (s)
      W_ACTIVE: n = W_TRCD;
      W_TRCD:   n = is_wr ? W_WRITE : W_READ;
      W_READ:   n = W_CL;
      W_CL:     n = W_RD;
      W_RD:     n = W_PRE;
      W_WRITE:  n = W_WD;
      W_WD:     n = W_TWR;
      W_TWR:    n = W_PRE;
      W_PRE:    n = W_TRP;
      W_AR:     n = W_TRFC;
      default:  n = W_IDLE;
    endcase
    return n;
  endfunction

  // Zero-length states never appear; they are never adjacent, so two hops is ample.
  function automatic work_state_e f_enter(input work_state_e s, input logic is_wr, input logic [9:0] bl);
    work_state_e t;
    t = s;
    for (int i = 0; i < 2; i++) begin
      if (t != W_IDLE && f_dur(t, bl) == 11'd0) t = f_succ(t, is_wr);
    end
    return t;
  endfunction

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_ref_clr),
    .o_ref_pend (w_ref_pend)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_is_wr = r_is_wr;
    w_nxt_bl    = r_bl;
    w_accept    = 1'b0;
    w_ref_clr   = 1'b0;
    w_pick_wr   = i_wr_req & (~i_rd_req | ~r_rd_next);
    w_last      = ({1'b0, r_cnt} == f_dur(r_state, r_bl) - 11'd1);

    if (r_state == W_IDLE) begin
      if (i_sdram_init_done) begin
        if (w_ref_pend) begin
          w_nxt_state = W_AR;
          w_nxt_is_wr = 1'b0;
          w_ref_clr   = 1'b1;
        end else if (i_wr_req | i_rd_req) begin
          w_accept    = 1'b1;
          w_nxt_state = W_ACTIVE;
          w_nxt_is_wr = w_pick_wr;
          w_nxt_bl    = clamp_bl(w_pick_wr ? i_wr_burst_len : i_rd_burst_len);
        end
      end
    end else if (w_last) begin
      w_nxt_state = f_enter(f_succ(r_state, r_is_wr), r_is_wr, r_bl);
    end

    if (w_nxt_state != r_state) w_nxt_cnt = 10'd0;
    else if (r_cnt == CNT_MAX)  w_nxt_cnt = r_cnt;
    else                        w_nxt_cnt = r_cnt + 10'd1;

    // Completion lands on the final cycle before returning to idle.
    w_done = (w_nxt_state == W_TRP && {1'b0, w_nxt_cnt} == f_dur(W_TRP, r_bl) - 11'd1) ||
             (w_nxt_state == W_PRE && f_dur(W_TRP, r_bl) == 11'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= W_IDLE;
      r_cnt      <= 10'd0;
      r_bl       <= 10'd1;
      r_is_wr    <= 1'b0;
      r_rd_next  <= 1'b0;
      r_rd_wr    <= 1'b1;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_bl       <= w_nxt_bl;
      r_is_wr    <= w_nxt_is_wr;
      if (w_accept) r_rd_next <= w_pick_wr;
      r_rd_wr    <= ~((w_nxt_state != W_IDLE) & w_nxt_is_wr);
      r_wr_ack   <= (w_nxt_state == W_WRITE) | (w_nxt_state == W_WD);
      r_rd_valid <= (r_state == W_RD);
      r_wr_done  <= w_done & w_nxt_is_wr;
      r_rd_done  <= w_done & ~w_nxt_is_wr;
      r_busy     <= (w_nxt_state != W_IDLE);
    end
  end

  assign o_work_state  = r_state;
  assign o_cnt_clk     = r_cnt;
  assign o_sdram_rd_wr = r_rd_wr;
  assign o_wr_ack      = r_wr_ack;
  assign o_rd_valid    = r_rd_valid;
  assign o_wr_done     = r_wr_done;
  assign o_rd_done     = r_rd_done;
  assign o_busy        = r_busy;

endmodule
